hazard_stall_unit: RTL and testbench
====================================

# hazard_stall_unit

Pipeline hazard controller for the KGP-RISC five-stage pipeline: it handles the hazards that operand forwarding cannot resolve. It detects load-use dependencies in ID, and sequences multi-cycle EX operations with an occupancy counter. It also flushes wrong-path instructions on a taken branch. It drives PC/IF-ID write enables, ID/EX bubble insertion, IF/ID flush and an EX hold, so the forwarding unit's sources are always valid when selected.

## Interface
- MUL_LAT, 4: total EX-stage cycles of a multi-cycle op (multiply/divide); legal range 2..16.
- REG_W, 5: register-address width.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- id_rs, id_rt  in  REG_W  source registers of the instruction in ID.
- id_uses_rs, id_uses_rt  in  1  instruction in ID actually reads rs / rt.
- id_ex_dest  in  REG_W  destination of the instruction in EX.
- id_ex_regwrite  in  1  instruction in EX writes the register file.
- id_ex_readdmem  in  1  instruction in EX is a load.
- id_ex_multi  in  1  instruction in EX is a multi-cycle op.
- branch_taken  in  1  taken branch/jump resolved in EX this cycle.
- pc_write_en  out  1  PC may update.
- if_id_write_en  out  1  IF/ID register may update.
- if_id_flush  out  1  IF/ID loads a NOP.
- id_ex_bubble  out  1  ID/EX loads a NOP (control bits zero).
- ex_hold  out  1  ID/EX and EX/MEM hold; EX/MEM receives a bubble.
- busy  out  1  FSM in BUSY.

## Operation
- FSM states: IDLE, BUSY. 4-bit down-counter cnt.
- Priority, highest first: rst, BUSY, branch_taken, multi-op entry, load-use, none.
- load_use = id_ex_readdmem & id_ex_regwrite & ((id_uses_rs & id_rs==id_ex_dest) | (id_uses_rt & id_rt==id_ex_dest)). Register 0 is not special-cased.
- IDLE, branch_taken=1: if_id_flush=1, id_ex_bubble=1, pc_write_en=1, if_id_write_en=1. Any concurrent load_use is discarded, because the ID instruction is wrong-path.
- IDLE, id_ex_multi=1, branch_taken=0: ex_hold=1, pc_write_en=0, if_id_write_en=0, id_ex_bubble=0. Next state is BUSY with cnt=MUL_LAT-2.
- IDLE, load_use=1, id_ex_multi=0: pc_write_en=0, if_id_write_en=0, id_ex_bubble=1. The stall is self-limiting to one cycle: the next cycle the load is in MEM, and forwarding from data memory resolves the dependency.
- IDLE, no event: pc_write_en=1, if_id_write_en=1, all others 0.
- BUSY, cnt!=0: same outputs as multi-op entry; cnt decrements.
- BUSY, cnt==0 (release cycle): ex_hold=0, pc_write_en=0, if_id_write_en=0, id_ex_bubble=1. Next state is IDLE.
- In BUSY, id_ex_multi, load_use and branch_taken are ignored. A branch cannot occupy EX alongside a multi-op; the bench asserts branch_taken=0 in BUSY.
- busy=1 exactly when the state is BUSY.

## Timing
- All hazard outputs are combinational from the current state and inputs, valid in the same cycle. State and cnt update on the clk rising edge.
- Reset: state=IDLE, cnt=0. While rst=1, outputs are forced to pc_write_en=0, if_id_write_en=0, if_id_flush=1, id_ex_bubble=1, ex_hold=0, busy=0.
- Reset asserted mid-BUSY aborts the op immediately. After rst deasserts, the first cycle is IDLE.
- A multi-op occupies EX for exactly MUL_LAT cycles: MUL_LAT-1 cycles with ex_hold, plus the release cycle.
- PC is frozen for MUL_LAT cycles in total.
- MUL_LAT=2: entry loads cnt=0. BUSY lasts one cycle, which is the release cycle.
- Load-use stall latency: 1 cycle. Branch flush penalty: 2 instructions (IF/ID and ID/EX).
- Back-to-back multi-ops: after release, the IDLE cycle re-evaluates id_ex_multi for the new EX occupant.

## Configuration
- HAZARD_STATS_EN defined adds two outputs:
  - stall_cycles (16 bits): increments every non-reset cycle in which pc_write_en=0.
  - flush_count (16 bits): increments on every IDLE branch_taken.
  - Both saturate at 16'hFFFF and reset to 0 asynchronously.
- HAZARD_STATS_EN undefined: the ports and counters are absent. Core behaviour is identical.

## Test plan
- Load-use: EX is a load (dest=5, regwrite=1, readdmem=1); ID uses rs=5 -> one cycle with pc_write_en=0, if_id_write_en=0, id_ex_bubble=1. Next cycle (EX bubble) returns to all enables=1.
- No false stall: EX is a load to r5; ID uses_rt=0 with rt=5, and rs=6 -> pc_write_en=1, id_ex_bubble=0.
- Multi-op, MUL_LAT=4: id_ex_multi=1 -> ex_hold=1 for 3 cycles, busy=1 in cycles 2-4. Cycle 4 has ex_hold=0 and id_ex_bubble=1; PC is frozen for 4 cycles; cycle 5 has pc_write_en=1.
- Branch vs load-use in the same cycle: branch_taken=1 and load_use=1 -> if_id_flush=1, id_ex_bubble=1, pc_write_en=1.
- Reset during BUSY: assert rst at cnt=1 -> outputs go to reset values without waiting for a clock. After release, state=IDLE and busy=0.
- With HAZARD_STATS_EN: one load-use stall, one MUL_LAT=4 op and two taken branches -> stall_cycles=5, flush_count=2. Forcing stall_cycles to 16'hFFFF and stalling again leaves it at 16'hFFFF.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: KGP-RISC hazard controller. It detects load-use stalls,
// sequences multi-cycle EX ops (two-state FSM with a down-counter) and flushes
// wrong-path instructions on a taken branch.
// Optional build macro HAZARD_STATS_EN adds saturating stall/flush counters.
module hazard_stall_unit #(
    parameter int MUL_LAT = 4,
    parameter int REG_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] id_ex_dest,
    input  logic             id_ex_regwrite,
    input  logic             id_ex_readdmem,
    input  logic             id_ex_multi,
    input  logic             branch_taken,
    output logic             pc_write_en,
    output logic             if_id_write_en,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_hold,
    output logic             busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]      stall_cycles,
    output logic [15:0]      flush_count
`endif
);

    typedef enum logic [0:0] {IDLE, BUSY} state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       load_use;

    // Register 0 is deliberately not special-cased.
    assign load_use = id_ex_readdmem & id_ex_regwrite &
                      ((id_uses_rs & (id_rs == id_ex_dest)) |
                       (id_uses_rt & (id_rt == id_ex_dest)));

    // State and occupancy counter; reset aborts any op in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and hazard outputs, by priority: rst, BUSY, branch, multi, load-use.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_bubble   = 1'b0;
        ex_hold        = 1'b0;
        if (rst) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            if_id_flush    = 1'b1;
            id_ex_bubble   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (branch_taken) begin
                        // ID holds a wrong-path instruction, so any load-use is moot.
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (id_ex_multi) begin
                        ex_hold        = 1'b1;
                        pc_write_en    = 1'b0;
                        if_id_write_en = 1'b0;
                        state_nxt      = BUSY;
                        cnt_nxt        = 4'(MUL_LAT - 2);
                    end else if (load_use) begin
                        pc_write_en    = 1'b0;
                        if_id_write_en = 1'b0;
                        id_ex_bubble   = 1'b1;
                    end
                end
                BUSY: begin
                    pc_write_en    = 1'b0;
                    if_id_write_en = 1'b0;
                    if (cnt != 4'd0) begin
                        ex_hold = 1'b1;
                        cnt_nxt = cnt - 4'd1;
                    end else begin
                        // Release cycle: result leaves EX, ID/EX gets a bubble.
                        id_ex_bubble = 1'b1;
                        state_nxt    = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign busy = (state == BUSY);

`ifdef HAZARD_STATS_EN
    // Saturating stall-cycle and branch-flush counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= 16'd0;
            flush_count  <= 16'd0;
        end else begin
            if (!pc_write_en && (stall_cycles != 16'hFFFF))
                stall_cycles <= stall_cycles + 16'd1;
            if ((state == IDLE) && branch_taken && (flush_count != 16'hFFFF))
                flush_count <= flush_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: directed test-plan scenarios followed by random
// stimulus, all checked against a cycle-level occupancy model.
module tb_hazard_stall_unit;

    localparam int MUL_LAT = 4;
    localparam int REG_W   = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [REG_W-1:0] id_rs = '0, id_rt = '0, id_ex_dest = '0;
    logic id_uses_rs = 0, id_uses_rt = 0, id_ex_regwrite = 0, id_ex_readdmem = 0;
    logic id_ex_multi = 0, branch_taken = 0;
    logic pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, ex_hold, busy;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cycles, flush_count;
    int stall_m = 0, flush_m = 0;
`endif

    int checks = 0;
    int fails  = 0;
    // Cycles of EX occupancy still owed by the current multi-op after this one.
    int ml     = 0;

    always #5 clk = ~clk;

    hazard_stall_unit #(.MUL_LAT(MUL_LAT), .REG_W(REG_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_ex_dest(id_ex_dest), .id_ex_regwrite(id_ex_regwrite),
        .id_ex_readdmem(id_ex_readdmem), .id_ex_multi(id_ex_multi),
        .branch_taken(branch_taken),
        .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
        .ex_hold(ex_hold), .busy(busy)
`ifdef HAZARD_STATS_EN
        , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
    );

    function automatic logic [5:0] outv();
        return {pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, ex_hold, busy};
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One cycle: drive at negedge, compare 1ns later, then advance the model.
    // Vector order: {pc_we, ifid_we, flush, bubble, hold, busy}.
    task automatic step(input string tag, input logic r,
                        input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                        input logic urs, input logic urt,
                        input logic [REG_W-1:0] dest, input logic rw, input logic rd,
                        input logic mul, input logic br);
        logic [5:0] e;
        logic lu;
        int ml_n;
        @(negedge clk);
        rst = r; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        id_ex_dest = dest; id_ex_regwrite = rw; id_ex_readdmem = rd;
        id_ex_multi = mul; branch_taken = br;
        #1;
        lu = rd && rw && ((urs && rs == dest) || (urt && rt == dest));
        ml_n = ml;
        if (r) begin
            e = 6'b001100; ml_n = 0;
        end else if (ml > 1) begin
            e = 6'b000011; ml_n = ml - 1;
        end else if (ml == 1) begin
            e = 6'b000101; ml_n = 0;
        end else if (br) begin
            e = 6'b111100;
        end else if (mul) begin
            e = 6'b000010; ml_n = MUL_LAT - 1;
        end else if (lu) begin
            e = 6'b000100;
        end else begin
            e = 6'b110000;
        end
        chk(tag, 16'(outv()), 16'(e));
`ifdef HAZARD_STATS_EN
        if (r) begin stall_m = 0; flush_m = 0; end
        chk({tag, "_stall"}, stall_cycles, 16'(stall_m));
        chk({tag, "_flush"}, flush_count, 16'(flush_m));
        if (!r) begin
            if (!e[5] && stall_m < 16'hFFFF) stall_m++;
            if (ml == 0 && br && flush_m < 16'hFFFF) flush_m++;
        end
`endif
        ml = ml_n;
    endtask

    initial begin
        // Reset values
        step("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_vec", 16'(outv()), 16'h000C);
        step("reset2", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Load-use on rs=r5, then EX holds the bubble
        step("load_use", 0, 5, 1, 1, 1, 5, 1, 1, 0, 0);
        chk("load_use_pc", 16'(pc_write_en), 16'h0000);
        step("lu_after", 0, 5, 1, 1, 1, 0, 0, 0, 0, 0);
        // rt=r5 but unused, rs=r6: no stall
        step("no_false", 0, 6, 5, 1, 0, 5, 1, 1, 0, 0);
        chk("no_false_pc", 16'(pc_write_en), 16'h0001);

        // Multi-op: entry + 3 BUSY cycles; id_ex_multi stays high but is ignored
        step("mul_c1", 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        step("mul_c2", 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        step("mul_c3", 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        step("mul_c4", 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        chk("mul_release", 16'(outv()), 16'h0005);
        step("mul_c5", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("mul_resume_pc", 16'(pc_write_en), 16'h0001);

        // Branch and load-use together: branch wins
        step("br_lu", 0, 7, 0, 1, 0, 7, 1, 1, 0, 1);
        step("br2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Back-to-back multi-ops
        step("b2b_1", 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        step("b2b_2", 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        step("b2b_3", 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        step("b2b_4", 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        step("b2b_5", 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        step("b2b_6", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step("b2b_7", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step("b2b_8", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset mid-BUSY at cnt=1, without a clock edge
        step("rb_1", 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        step("rb_2", 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        step("rb_3", 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        #1 rst = 1'b1;
        #1 chk("rst_async", 16'(outv()), 16'h000C);
        ml = 0;
`ifdef HAZARD_STATS_EN
        stall_m = 0; flush_m = 0;
`endif
        step("rb_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rb_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rb_busy", 16'(busy), 16'h0000);

        // Random traffic; registers drawn from a small pool to provoke matches
        for (int i = 0; i < 500; i++) begin
            logic r, m, b;
            r = ($urandom_range(0, 49) == 0);
            m = ($urandom_range(0, 7) == 0);
            b = (ml == 0) ? ($urandom_range(0, 5) == 0) : 1'b0;
            step("rand", r,
                 REG_W'($urandom_range(0, 3)), REG_W'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom),
                 REG_W'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), m, b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
